// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the serial adder controller.
package serial_adder_pkg;

  // Largest operand width the controller is meant to be built with.
  localparam int unsigned WIDTH_MAX = 32;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder built from two half adders plus an OR for the carry.
module serial_fa_cell
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g1;
  logic g2;

  // First half adder on the operands, second on the partial sum and carry-in.
  always_comb begin
    p    = a ^ b;
    g1   = a & b;
    s    = p ^ cin;
    g2   = p & cin;
    cout = g1 | g2;
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts WIDTH-bit operands on start, adds them LSB first one bit
// per enabled cycle, then presents sum/cout with a done pulse.
// Optional feature: define SERIAL_SUB_EN to enable A-B via the sub input.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             bit_s;
  logic             bit_c;

`ifdef SERIAL_SUB_EN
  // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
  always_comb begin
    b_load = sub ? ~b_in : b_in;
    c_load = sub;
  end
`else
  logic unused_sub;
  assign unused_sub = sub;

  // Addition only; the sub input has no effect in this build.
  always_comb begin
    b_load = b_in;
    c_load = 1'b0;
  end
`endif

  serial_fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (bit_s),
    .cout (bit_c)
  );

  // Sequencer: accept operands, shift one bit per enabled cycle, publish result on the last bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= StIdle;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
    end else if (ena) begin
      unique case (state)
        StIdle: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end
        end
        StRun: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {bit_s, sum_sh[WIDTH-1:1]};
          carry  <= bit_c;
          cnt    <= cnt + 1'b1;
          if (cnt == LastBit) begin
            // Outputs only change here so they hold the previous result during RUN.
            sum   <= {bit_s, sum_sh[WIDTH-1:1]};
            cout  <= bit_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
